// File: rtl/midi_tx_if.sv
// Event handshake between an upstream producer and the MIDI transmitter.
// Packing: [23:16] status, [15:8] data1, [7:0] data2.
interface midi_tx_if;
  logic [23:0] event_in;
  logic        event_valid_in;
  logic        event_ready_out;

  modport master (output event_in, output event_valid_in, input event_ready_out);
  modport slave  (input event_in, input event_valid_in, output event_ready_out);
endinterface

// File: rtl/midi_tx.sv
// Serialises 24-bit MIDI events onto a UART line (8N1, idle high), with optional running status.
//
// state | meaning
// IDLE  | line high, ready for an event
// START | driving start bit (0)
// DATA  | driving 8 data bits, LSB first
// STOP  | driving stop bit (1); then next byte or IDLE
module midi_tx #(
  parameter int CLKS_PER_BIT   = 3200,
  parameter bit RUNNING_STATUS = 1'b0
) (
  input  logic      clk_in,
  input  logic      rst_in,
  midi_tx_if.slave  evt,
  output logic      tx_out,
  output logic      busy_out,
  output logic      drop_out
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_LOAD = TW'(CLKS_PER_BIT - 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [15:0]   rest;
  logic [1:0]    left;
  logic [7:0]    run_status;
  logic          ready_r;

  logic [7:0]  s, d1, d2;
  logic        is_cv, is_rt, skip;
  logic [1:0]  msg_len;
  logic [23:0] msg_bytes;

  assign s     = evt.event_in[23:16];
  assign d1    = evt.event_in[15:8] & 8'h7F;
  assign d2    = evt.event_in[7:0] & 8'h7F;
  assign is_cv = s[7] && (s[7:4] != 4'hF);
  assign is_rt = (s[7:3] == 5'b11111);
  assign skip  = RUNNING_STATUS && is_cv && (s == run_status);

  assign evt.event_ready_out = ready_r;

  // First byte to send sits in msg_bytes[7:0]; later bytes follow upward.
  always_comb begin
    msg_len   = 2'd0;
    msg_bytes = 24'h0;
    if (is_rt) begin
      msg_len   = 2'd1;
      msg_bytes = {16'h0, s};
    end else if (is_cv) begin
      if (s[7:4] == 4'hC || s[7:4] == 4'hD) begin
        msg_len   = skip ? 2'd1 : 2'd2;
        msg_bytes = skip ? {16'h0, d1} : {8'h0, d1, s};
      end else begin
        msg_len   = skip ? 2'd2 : 2'd3;
        msg_bytes = skip ? {8'h0, d2, d1} : {d2, d1, s};
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      timer      <= '0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h0;
      rest       <= 16'h0;
      left       <= 2'd0;
      run_status <= 8'h0;
      ready_r    <= 1'b1;
      tx_out     <= 1'b1;
      busy_out   <= 1'b0;
      drop_out   <= 1'b0;
    end else begin
      drop_out <= 1'b0;
      case (state)
        IDLE: begin
          if (evt.event_valid_in && ready_r) begin
            if (msg_len == 2'd0) begin
              drop_out   <= 1'b1;
              run_status <= 8'h0;
            end else begin
              if (is_cv) run_status <= s;
              shreg    <= msg_bytes[7:0];
              rest     <= msg_bytes[23:8];
              left     <= msg_len - 2'd1;
              timer    <= BIT_LOAD;
              tx_out   <= 1'b0;
              busy_out <= 1'b1;
              ready_r  <= 1'b0;
              state    <= START;
            end
          end
        end
        START: begin
          if (timer == '0) begin
            timer   <= BIT_LOAD;
            tx_out  <= shreg[0];
            bit_idx <= 3'd0;
            state   <= DATA;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        DATA: begin
          if (timer == '0) begin
            timer <= BIT_LOAD;
            if (bit_idx == 3'd7) begin
              tx_out <= 1'b1;
              state  <= STOP;
            end else begin
              tx_out  <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        STOP: begin
          if (timer == '0) begin
            if (left != 2'd0) begin
              // Next byte starts immediately: no gap beyond the stop bit.
              shreg  <= rest[7:0];
              rest   <= {8'h0, rest[15:8]};
              left   <= left - 2'd1;
              timer  <= BIT_LOAD;
              tx_out <= 1'b0;
              state  <= START;
            end else begin
              busy_out <= 1'b0;
              ready_r  <= 1'b1;
              state    <= IDLE;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
